mbinit_cal_handshake: RTL and testbench
=======================================

Name: mbinit_cal_handshake

Overview:
- MBINIT.CAL stage. Runs directly after the PARAM wrapper signals its end; the MBINIT controller raises i_CAL_start_en when that happens.
- Performs the two-sided sideband exchange:
  - Local side sends CAL_DONE_REQ and waits for CAL_DONE_RESP.
  - Partner side waits for the remote CAL_DONE_REQ and answers with CAL_DONE_RESP.
- Shares a single sideband TX port between the two sides and raises a training-error request on timeout.

Parameters:
MSG_CAL_DONE_REQ, 4'd5, sideband encoding of MBINIT.CAL_Done req
MSG_CAL_DONE_RESP, 4'd6, sideband encoding of MBINIT.CAL_Done resp
TIMEOUT_CYCLES, 800000, cycles from start to error (8 ms at 100 MHz); counter width 20 bits

Ports:
CLK  in  1  clock
rst  in  1  synchronous active-high reset
i_CAL_start_en  in  1  level enable from MBINIT controller; low = abort/idle
i_RX_SbMessage  in  4  decoded received sideband message
i_msg_valid  in  1  1-cycle strobe qualifying i_RX_SbMessage
i_falling_edge_busy  in  1  1-cycle pulse: sideband TX accepted current message
o_TX_SbMessage  out  4  message to transmit
o_ValidOutDatat  out  1  TX request, held until accepted
o_MBINIT_CAL_end  out  1  both sides complete
o_train_error_req  out  1  timeout, sticky while enabled

Behaviour:
- Reset and state conventions
  - rst high: all outputs 0, both FSMs in IDLE, timeout counter 0, TX owner none.
  - All outputs are registered.
- Local FSM: L_IDLE -> L_SEND_REQ -> L_WAIT_RESP -> L_DONE
  - L_IDLE -> L_SEND_REQ on i_CAL_start_en rising (enable high while in IDLE).
  - L_SEND_REQ: requests TX with MSG_CAL_DONE_REQ. Goes to L_WAIT_RESP on i_falling_edge_busy while it owns TX.
  - L_WAIT_RESP -> L_DONE on i_msg_valid && i_RX_SbMessage==MSG_CAL_DONE_RESP.
- Partner FSM: P_IDLE -> P_WAIT_REQ -> P_SEND_RESP -> P_DONE
  - Enters P_WAIT_REQ the same cycle the local FSM leaves L_IDLE.
  - P_WAIT_REQ -> P_SEND_RESP on i_msg_valid && i_RX_SbMessage==MSG_CAL_DONE_REQ.
  - P_SEND_RESP -> P_DONE on i_falling_edge_busy while it owns TX.
- Early/late messages
  - A RESP seen while the local FSM is still in L_SEND_REQ sets a 1-bit resp_seen flag. L_WAIT_RESP then exits on the flag in its first cycle.
  - A REQ seen during P_SEND_RESP or P_DONE is ignored; the partner side never re-responds.
  - All other message codes and messages with i_msg_valid low are ignored.
- TX arbitration
  - Owner register: NONE/LOCAL/PARTNER.
  - When NONE and both sides request in the same cycle, LOCAL wins; PARTNER is granted after LOCAL is accepted.
  - Once granted, the owner holds o_TX_SbMessage and o_ValidOutDatat=1 until i_falling_edge_busy. Both drop the next cycle, with one idle cycle minimum between messages.
  - i_falling_edge_busy while owner==NONE is ignored.
- Latency
  - start_en rises at cycle N: o_ValidOutDatat=1 with REQ at N+1.
  - Accept pulse at cycle M: o_ValidOutDatat=0 at M+1.
- Completion
  - o_MBINIT_CAL_end=1 the cycle after both FSMs reach DONE. It is held while i_CAL_start_en stays high.
- Timeout
  - Counter runs while enabled and not complete.
  - On reaching TIMEOUT_CYCLES-1: o_train_error_req=1 next cycle, both FSMs go to ERR, and TX is released (o_ValidOutDatat=0).
  - Stays in ERR until enable drops.
  - If completion and timeout occur in the same cycle, completion wins.
- Abort
  - i_CAL_start_en low at any point: next cycle both FSMs go to IDLE and all outputs, counter, flags and owner clear.
  - A message in flight is dropped.
  - Reset mid-operation behaves identically.
- Widths
  - Counter saturates and does not wrap.
  - Message fields pass through unmodified; parameter widths are fixed at 4.

Test Plan:
- Normal flow: start_en=1 at c0; accept at c3; RESP at c6; REQ at c8; accept at c11 -> REQ=5 valid c1–c3, RESP=6 valid c10–c11, o_MBINIT_CAL_end=1 at c13.
- Simultaneous request: partner REQ arrives at c0 with start_en -> LOCAL sends 5 first; after accept, one idle cycle, then 6; end asserts after RESP received.
- Early RESP: RESP=6 arrives before the REQ accept pulse -> resp_seen set; local reaches DONE one cycle after accept; no second wait.
- Timeout: TIMEOUT_CYCLES=20, no RX messages -> o_train_error_req=1 at cycle 20, o_ValidOutDatat=0, end stays 0; start_en low clears the error next cycle.
- Abort: start_en dropped while REQ is pending -> all outputs 0 next cycle; re-raising start_en restarts with REQ at +1 cycle.
- Noise: message 4'd9 with valid, REQ with i_msg_valid=0, and an accept pulse with no owner -> no state change.

Source files
------------

// File: rtl/mbinit_cal_handshake.sv
// MBINIT.CAL two-sided sideband handshake: local CAL_DONE req/resp and partner answer,
// sharing one sideband TX port, with a training-error timeout.
module mbinit_cal_handshake #(
    parameter logic [3:0]  MSG_CAL_DONE_REQ  = 4'd5,
    parameter logic [3:0]  MSG_CAL_DONE_RESP = 4'd6,
    parameter int unsigned TIMEOUT_CYCLES    = 800000
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       i_CAL_start_en,
    input  logic [3:0] i_RX_SbMessage,
    input  logic       i_msg_valid,
    input  logic       i_falling_edge_busy,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutDatat,
    output logic       o_MBINIT_CAL_end,
    output logic       o_train_error_req
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {L_IDLE, L_SEND_REQ, L_WAIT_RESP, L_DONE, L_ERR} loc_state_t;
    typedef enum logic [2:0] {P_IDLE, P_WAIT_REQ, P_SEND_RESP, P_DONE, P_ERR} par_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_LOCAL, OWN_PARTNER} owner_t;

    loc_state_t       r_loc, w_loc_nxt;
    par_state_t       r_par, w_par_nxt;
    owner_t           r_owner, w_owner_nxt;
    logic [3:0]       r_tx_msg, w_tx_msg_nxt;
    logic             r_tx_vld, w_tx_vld_nxt;
    logic             r_end, w_end_nxt;
    logic             r_err, w_err_nxt;
    logic             r_resp_seen, w_resp_seen_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic w_req_hit, w_resp_hit, w_loc_acc, w_par_acc;
    logic w_loc_rq, w_par_rq, w_both_done, w_done_nxt;

    assign w_req_hit   = i_msg_valid && (i_RX_SbMessage == MSG_CAL_DONE_REQ);
    assign w_resp_hit  = i_msg_valid && (i_RX_SbMessage == MSG_CAL_DONE_RESP);
    assign w_loc_acc   = i_falling_edge_busy && (r_owner == OWN_LOCAL);
    assign w_par_acc   = i_falling_edge_busy && (r_owner == OWN_PARTNER);
    assign w_both_done = (r_loc == L_DONE) && (r_par == P_DONE);
    // Local asks for TX already in its IDLE->SEND_REQ cycle so REQ appears one cycle after start.
    assign w_loc_rq    = ((r_loc == L_IDLE) && i_CAL_start_en) || (r_loc == L_SEND_REQ);
    assign w_par_rq    = (r_par == P_SEND_RESP);

    always_comb begin
        w_loc_nxt       = r_loc;
        w_par_nxt       = r_par;
        w_owner_nxt     = r_owner;
        w_tx_msg_nxt    = r_tx_msg;
        w_tx_vld_nxt    = r_tx_vld;
        w_end_nxt       = w_both_done;
        w_err_nxt       = r_err;
        w_resp_seen_nxt = r_resp_seen;
        w_cnt_nxt       = r_cnt;
        w_done_nxt      = 1'b0;

        case (r_loc)
            L_IDLE:      if (i_CAL_start_en) w_loc_nxt = L_SEND_REQ;
            L_SEND_REQ: begin
                if (w_resp_hit) w_resp_seen_nxt = 1'b1;
                if (w_loc_acc)  w_loc_nxt = L_WAIT_RESP;
            end
            L_WAIT_RESP: if (r_resp_seen || w_resp_hit) w_loc_nxt = L_DONE;
            default:     w_loc_nxt = r_loc;
        endcase

        // A REQ arriving together with start is already the partner's trigger.
        case (r_par)
            P_IDLE:      if (i_CAL_start_en) w_par_nxt = w_req_hit ? P_SEND_RESP : P_WAIT_REQ;
            P_WAIT_REQ:  if (w_req_hit) w_par_nxt = P_SEND_RESP;
            P_SEND_RESP: if (w_par_acc) w_par_nxt = P_DONE;
            default:     w_par_nxt = r_par;
        endcase

        if (r_owner == OWN_NONE) begin
            if (w_loc_rq) begin
                w_owner_nxt  = OWN_LOCAL;
                w_tx_msg_nxt = MSG_CAL_DONE_REQ;
                w_tx_vld_nxt = 1'b1;
            end else if (w_par_rq) begin
                w_owner_nxt  = OWN_PARTNER;
                w_tx_msg_nxt = MSG_CAL_DONE_RESP;
                w_tx_vld_nxt = 1'b1;
            end
        end else if (i_falling_edge_busy) begin
            w_owner_nxt  = OWN_NONE;
            w_tx_msg_nxt = 4'd0;
            w_tx_vld_nxt = 1'b0;
        end

        if (!w_both_done && !r_err && (r_cnt != '1))
            w_cnt_nxt = r_cnt + 1'b1;

        // Completion reached on this edge beats a simultaneous timeout.
        w_done_nxt = (w_loc_nxt == L_DONE) && (w_par_nxt == P_DONE);
        if (!r_err && (r_cnt == CNT_LAST) && !w_done_nxt) begin
            w_loc_nxt    = L_ERR;
            w_par_nxt    = P_ERR;
            w_owner_nxt  = OWN_NONE;
            w_tx_msg_nxt = 4'd0;
            w_tx_vld_nxt = 1'b0;
            w_err_nxt    = 1'b1;
        end
    end

    // Dropping the enable clears everything exactly like reset, including any message in flight.
    always_ff @(posedge CLK) begin
        if (rst || !i_CAL_start_en) begin
            r_loc       <= L_IDLE;
            r_par       <= P_IDLE;
            r_owner     <= OWN_NONE;
            r_tx_msg    <= 4'd0;
            r_tx_vld    <= 1'b0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
            r_resp_seen <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_loc       <= w_loc_nxt;
            r_par       <= w_par_nxt;
            r_owner     <= w_owner_nxt;
            r_tx_msg    <= w_tx_msg_nxt;
            r_tx_vld    <= w_tx_vld_nxt;
            r_end       <= w_end_nxt;
            r_err       <= w_err_nxt;
            r_resp_seen <= w_resp_seen_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign o_TX_SbMessage    = r_tx_msg;
    assign o_ValidOutDatat   = r_tx_vld;
    assign o_MBINIT_CAL_end  = r_end;
    assign o_train_error_req = r_err;

endmodule

// File: tb/tb_mbinit_cal_handshake.sv
// Directed bench for mbinit_cal_handshake: one call per clock cycle drives inputs and
// compares {valid, msg, end, err} against hand-derived values for that cycle.
module tb_mbinit_cal_handshake;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] rx_msg;
    logic       mv;
    logic       busy;
    logic [3:0] tx_msg;
    logic       tx_vld;
    logic       cal_end;
    logic       err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mbinit_cal_handshake #(
        .MSG_CAL_DONE_REQ  (4'd5),
        .MSG_CAL_DONE_RESP (4'd6),
        .TIMEOUT_CYCLES    (20)
    ) dut (
        .CLK                 (clk),
        .rst                 (rst),
        .i_CAL_start_en      (en),
        .i_RX_SbMessage      (rx_msg),
        .i_msg_valid         (mv),
        .i_falling_edge_busy (busy),
        .o_TX_SbMessage      (tx_msg),
        .o_ValidOutDatat     (tx_vld),
        .o_MBINIT_CAL_end    (cal_end),
        .o_train_error_req   (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got {vld,msg,end,err}=%07b expected %07b", tag, got[6:0], exp[6:0]);
        end
    endtask

    // Drive cycle inputs, compare this cycle's registered outputs, then advance one clock.
    task automatic step(input string tag, input logic i_en, input logic i_mv, input logic [3:0] i_msg,
                        input logic i_busy, input logic ev, input logic [3:0] em,
                        input logic ee, input logic er);
        en     = i_en;
        mv     = i_mv;
        rx_msg = i_msg;
        busy   = i_busy;
        chk(tag, {25'd0, tx_vld, tx_msg, cal_end, err}, {25'd0, ev, em, ee, er});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rx_msg = 4'd0; mv = 1'b0; busy = 1'b0;
        @(posedge clk); #1;
        step("rst0", 1, 0, 0, 0,  0, 0, 0, 0);
        step("rst1", 1, 1, 5, 1,  0, 0, 0, 0);
        rst = 1'b0;
        step("idle", 0, 0, 0, 0,  0, 0, 0, 0);

        // Normal flow
        step("nrm c0",  1, 0, 0, 0,  0, 0, 0, 0);
        step("nrm c1",  1, 0, 0, 0,  1, 5, 0, 0);
        step("nrm c2",  1, 0, 0, 0,  1, 5, 0, 0);
        step("nrm c3",  1, 0, 0, 1,  1, 5, 0, 0);
        step("nrm c4",  1, 0, 0, 0,  0, 0, 0, 0);
        step("nrm c5",  1, 0, 0, 0,  0, 0, 0, 0);
        step("nrm c6",  1, 1, 6, 0,  0, 0, 0, 0);
        step("nrm c7",  1, 0, 0, 0,  0, 0, 0, 0);
        step("nrm c8",  1, 1, 5, 0,  0, 0, 0, 0);
        step("nrm c9",  1, 0, 0, 0,  0, 0, 0, 0);
        step("nrm c10", 1, 0, 0, 0,  1, 6, 0, 0);
        step("nrm c11", 1, 0, 0, 1,  1, 6, 0, 0);
        step("nrm c12", 1, 0, 0, 0,  0, 0, 0, 0);
        step("nrm c13", 1, 0, 0, 0,  0, 0, 1, 0);
        step("nrm c14", 0, 0, 0, 0,  0, 0, 1, 0);
        step("nrm c15", 0, 0, 0, 0,  0, 0, 0, 0);

        // Partner REQ together with start: local REQ first, idle gap, then RESP
        step("sim c0",  1, 1, 5, 0,  0, 0, 0, 0);
        step("sim c1",  1, 0, 0, 0,  1, 5, 0, 0);
        step("sim c2",  1, 0, 0, 1,  1, 5, 0, 0);
        step("sim c3",  1, 0, 0, 0,  0, 0, 0, 0);
        step("sim c4",  1, 0, 0, 0,  1, 6, 0, 0);
        step("sim c5",  1, 0, 0, 1,  1, 6, 0, 0);
        step("sim c6",  1, 1, 6, 0,  0, 0, 0, 0);
        step("sim c7",  1, 0, 0, 0,  0, 0, 0, 0);
        step("sim c8",  1, 0, 0, 0,  0, 0, 1, 0);
        step("sim c9",  0, 0, 0, 0,  0, 0, 1, 0);
        step("sim c10", 0, 0, 0, 0,  0, 0, 0, 0);

        // Early RESP while REQ still pending
        step("erl c0",  1, 1, 5, 0,  0, 0, 0, 0);
        step("erl c1",  1, 1, 6, 0,  1, 5, 0, 0);
        step("erl c2",  1, 0, 0, 1,  1, 5, 0, 0);
        step("erl c3",  1, 0, 0, 0,  0, 0, 0, 0);
        step("erl c4",  1, 0, 0, 0,  1, 6, 0, 0);
        step("erl c5",  1, 0, 0, 1,  1, 6, 0, 0);
        step("erl c6",  1, 0, 0, 0,  0, 0, 0, 0);
        step("erl c7",  1, 0, 0, 0,  0, 0, 1, 0);
        step("erl c8",  0, 0, 0, 0,  0, 0, 1, 0);
        step("erl c9",  0, 0, 0, 0,  0, 0, 0, 0);

        // Noise: unknown code, unqualified REQ, accept with no owner
        step("nse c0",  1, 0, 0, 0,  0, 0, 0, 0);
        step("nse c1",  1, 1, 9, 0,  1, 5, 0, 0);
        step("nse c2",  1, 0, 5, 0,  1, 5, 0, 0);
        step("nse c3",  1, 0, 0, 1,  1, 5, 0, 0);
        step("nse c4",  1, 0, 0, 1,  0, 0, 0, 0);
        step("nse c5",  1, 1, 5, 0,  0, 0, 0, 0);
        step("nse c6",  1, 0, 0, 0,  0, 0, 0, 0);
        step("nse c7",  1, 0, 0, 0,  1, 6, 0, 0);
        step("nse c8",  1, 0, 0, 1,  1, 6, 0, 0);
        step("nse c9",  1, 1, 6, 0,  0, 0, 0, 0);
        step("nse c10", 1, 0, 0, 0,  0, 0, 0, 0);
        step("nse c11", 1, 0, 0, 0,  0, 0, 1, 0);
        step("nse c12", 0, 0, 0, 0,  0, 0, 1, 0);
        step("nse c13", 0, 0, 0, 0,  0, 0, 0, 0);

        // Timeout with no RX traffic and no accept
        step("tmo c0",  1, 0, 0, 0,  0, 0, 0, 0);
        step("tmo c1",  1, 0, 0, 0,  1, 5, 0, 0);
        for (int k = 2; k <= 19; k++)
            step($sformatf("tmo c%0d", k), 1, 0, 0, 0,  1, 5, 0, 0);
        step("tmo c20", 1, 0, 0, 0,  0, 0, 0, 1);
        step("tmo c21", 1, 0, 0, 0,  0, 0, 0, 1);
        step("tmo c22", 0, 0, 0, 0,  0, 0, 0, 1);
        step("tmo c23", 0, 0, 0, 0,  0, 0, 0, 0);

        // Abort with REQ pending, restart, then reset mid-operation
        step("abt c0",  1, 0, 0, 0,  0, 0, 0, 0);
        step("abt c1",  1, 0, 0, 0,  1, 5, 0, 0);
        step("abt c2",  0, 0, 0, 0,  1, 5, 0, 0);
        step("abt c3",  1, 0, 0, 0,  0, 0, 0, 0);
        rst = 1'b1;
        step("abt c4",  1, 0, 0, 0,  1, 5, 0, 0);
        rst = 1'b0;
        step("abt c5",  1, 0, 0, 0,  0, 0, 0, 0);
        step("abt c6",  1, 0, 0, 0,  1, 5, 0, 0);
        step("abt c7",  0, 0, 0, 0,  1, 5, 0, 0);
        step("abt c8",  0, 0, 0, 0,  0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
